// File: rtl/boot_loader.sv
// Serial program loader: receives a counted, XOR-checksummed frame of 16-bit words,
// writes them to program memory, then releases the CPU from reset or flags an error.
module boot_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StCntHi, StCntLo, StDatHi, StDatLo, StChk, StRun, StErr
  } state_e;

  localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

  state_e            r_state, w_state;
  logic [7:0]        r_hi, w_hi;
  logic [7:0]        r_csum, w_csum;
  logic [16:0]       r_remain, w_remain;
  logic [31:0]       r_tmo, w_tmo;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [15:0]       r_wdata, w_wdata;
  logic [16:0]       w_count;
  logic              w_live;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StCntHi;
      r_hi     <= '0;
      r_csum   <= '0;
      r_remain <= '0;
      r_tmo    <= '0;
      r_idx    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_state;
      r_hi     <= w_hi;
      r_csum   <= w_csum;
      r_remain <= w_remain;
      r_tmo    <= w_tmo;
      r_idx    <= w_idx;
      r_we     <= w_we;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_hi     = r_hi;
    w_csum   = r_csum;
    w_remain = r_remain;
    w_tmo    = r_tmo;
    w_idx    = r_idx;
    w_we     = 1'b0;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_count  = {1'b0, r_hi, rx_data};
    w_live   = (r_state == StCntLo) || (r_state == StDatHi) ||
               (r_state == StDatLo) || (r_state == StChk);

    if (rx_valid) begin
      w_tmo = '0;
      if (w_live || r_state == StCntHi) begin
        w_csum = r_csum ^ rx_data;
      end
      case (r_state)
        StCntHi: begin
          w_hi    = rx_data;
          w_state = StCntLo;
        end
        StCntLo: begin
          w_remain = w_count;
          if (w_count > MaxWords) begin
            w_state = StErr;
          end else if (w_count == '0) begin
            w_state = StChk;
          end else begin
            w_state = StDatHi;
          end
        end
        StDatHi: begin
          w_hi    = rx_data;
          w_state = StDatLo;
        end
        StDatLo: begin
          w_we     = 1'b1;
          w_addr   = r_idx;
          w_wdata  = {r_hi, rx_data};
          w_idx    = r_idx + ADDR_W'(1);
          w_remain = r_remain - 17'd1;
          w_state  = (r_remain == 17'd1) ? StChk : StDatHi;
        end
        StChk: begin
          w_state = (rx_data == r_csum) ? StRun : StErr;
        end
        default: begin
          // RUN and ERR are sticky; bytes are dropped
        end
      endcase
    end else if (w_live) begin
      if (r_tmo == 32'(TIMEOUT - 1)) begin
        w_state = StErr;
      end else begin
        w_tmo = r_tmo + 32'd1;
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign done      = (r_state == StRun);
  assign err       = (r_state == StErr);
  assign cpu_reset = (r_state != StRun);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table of whole frames plus hand-written sequences for
// timeout, reset mid-load, a full-depth frame and post-completion behaviour.
module tb_boot_loader;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          cpu_reset, done, err;

  int errors = 0;
  int checks = 0;
  logic [23:0] wq[$];

  boot_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    checks++;
    if (done && err) begin
      errors++;
      $display("FAIL done_err_exclusive: done=%b err=%b required not both 1", done, err);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu",   32'(cpu_reset), 32'd1);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    wq.delete();
  endtask

  typedef struct {
    string       name;
    logic [63:0] bytes;
    int          len;
    logic        exp_done;
    logic        exp_err;
    int          exp_nw;
    logic [23:0] w0;
    logic [23:0] w1;
  } vec_t;

  vec_t vec[7];

  initial begin
    logic [7:0] cs;
    int         bad;

    // XOR of 00 02 12 34 AB CD is 0x42, so 0x40 is a checksum mismatch
    vec[0] = '{"good2",    64'h0002_1234_ABCD_4200, 7, 1'b1, 1'b0, 2, 24'h00_1234, 24'h01_ABCD};
    vec[1] = '{"bad1",     64'h0001_1234_0000_0000, 5, 1'b0, 1'b1, 1, 24'h00_1234, 24'h0};
    vec[2] = '{"ovf257",   64'h0101_0000_0000_0000, 2, 1'b0, 1'b1, 0, 24'h0, 24'h0};
    vec[3] = '{"empty",    64'h0000_0000_0000_0000, 3, 1'b1, 1'b0, 0, 24'h0, 24'h0};
    vec[4] = '{"one",      64'h0001_FF00_FE00_0000, 5, 1'b1, 1'b0, 1, 24'h00_FF00, 24'h0};
    vec[5] = '{"sum40",    64'h0002_1234_ABCD_4000, 7, 1'b0, 1'b1, 2, 24'h00_1234, 24'h01_ABCD};
    vec[6] = '{"emptybad", 64'h0000_0500_0000_0000, 3, 1'b0, 1'b1, 0, 24'h0, 24'h0};

    for (int t = 0; t < 7; t++) begin
      do_reset();
      for (int i = 0; i < vec[t].len; i++) send(vec[t].bytes[63-8*i -: 8]);
      check({vec[t].name, "_done"}, 32'(done),      32'(vec[t].exp_done));
      check({vec[t].name, "_err"},  32'(err),       32'(vec[t].exp_err));
      check({vec[t].name, "_cpu"},  32'(cpu_reset), 32'(!vec[t].exp_done));
      tick(2);
      check({vec[t].name, "_nw"}, 32'(wq.size()), 32'(vec[t].exp_nw));
      if (vec[t].exp_nw > 0 && wq.size() > 0) check({vec[t].name, "_w0"}, 32'(wq[0]), 32'(vec[t].w0));
      if (vec[t].exp_nw > 1 && wq.size() > 1) check({vec[t].name, "_w1"}, 32'(wq[1]), 32'(vec[t].w1));
    end

    // Timeout: exactly TMO idle cycles after a byte mid-frame
    do_reset();
    send(8'h00); send(8'h01); send(8'h12);
    tick(TMO - 1);
    check("tmo_before", 32'(err), 32'd0);
    tick(1);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_cpu", 32'(cpu_reset), 32'd1);
    send(8'h34); send(8'h27);
    tick(2);
    check("tmo_ignored_err", 32'(err), 32'd1);
    check("tmo_nw", 32'(wq.size()), 32'd0);

    // Reset mid-load, long idle in CNT_HI, then a frame with a TMO-1 gap
    do_reset();
    send(8'h00); send(8'h02); send(8'h12);
    reset = 1'b1;
    #1;
    check("midrst_addr", 32'(mem_addr), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(TMO + 10);
    check("idle_cnthi_err", 32'(err), 32'd0);
    send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    tick(TMO - 1);
    send(8'hAB); send(8'hCD);
    check("gap_addr_hold", 32'(mem_addr), 32'd1);
    check("gap_data",      32'(mem_wdata), 32'hABCD);
    send(8'h42);
    check("midrst_done", 32'(done), 32'd1);
    tick(1);
    check("midrst_nw", 32'(wq.size()), 32'd2);
    if (wq.size() > 0) check("midrst_w0", 32'(wq[0]), 32'h00_1234);
    if (wq.size() > 1) check("midrst_w1", 32'(wq[1]), 32'h01_ABCD);

    // Full depth: N = 256 is legal
    do_reset();
    cs = 8'h01;
    send(8'h01); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      send(~8'(i));
      cs = cs ^ 8'(i) ^ ~8'(i);
    end
    send(cs);
    check("full_done", 32'(done), 32'd1);
    tick(1);
    check("full_nw", 32'(wq.size()), 32'd256);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) begin
      if (wq[i] !== {8'(i), 8'(i), ~8'(i)}) bad++;
    end
    check("full_words", 32'(bad), 32'd0);
    check("full_addr_hold", 32'(mem_addr), 32'd255);
    check("full_data_hold", 32'(mem_wdata), 32'hFF00);

    // Bytes after completion are ignored
    send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h27);
    tick(2);
    check("run_sticky", 32'(done), 32'd1);
    check("run_nw", 32'(wq.size()), 32'd256);

    reset = 1'b1;
    #1;
    check("async_done", 32'(done), 32'd0);
    check("async_cpu",  32'(cpu_reset), 32'd1);
    check("async_addr", 32'(mem_addr), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
